// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler
//   Moves one audio frame at a time from the mic capture path through the FFT
//   engine into the display spectrum buffer:
//     IDLE -> LOAD  on the first mic write to address 0
//     LOAD -> RUN   on mic_start (one-cycle fft_start pulse)
//     RUN  -> DUMP  on fft_done, or RUN -> IDLE on watchdog expiry
//     DUMP -> IDLE  after the lower half-spectrum has been copied and scaled
//   Frames that arrive while the pipeline is busy are dropped and counted.
//
//   Optional feature macro: FFT_PEAK_HOLD_EN
//     When defined, every display bin decays by one per frame unless the new
//     magnitude is larger (peak hold with linear fall-off).
module fft_frame_scheduler #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 18,
  parameter int OUT_WIDTH    = 8,
  parameter int SHIFT        = 10,
  parameter int TIMEOUT_BITS = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mic_we,
  input  logic [ADDR_WIDTH-1:0] mic_addr,
  input  logic [DATA_WIDTH-1:0] mic_data,
  input  logic                  mic_start,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  fft_start,
  input  logic                  fft_done,
  output logic [ADDR_WIDTH-2:0] fft_rd_addr,
  input  logic [DATA_WIDTH-1:0] fft_rd_data,
  output logic                  disp_we,
  output logic [ADDR_WIDTH-2:0] disp_addr,
  output logic [OUT_WIDTH-1:0]  disp_data,
  output logic                  frame_ready,
  output logic [7:0]            overrun_cnt,
  output logic                  fft_timeout,
  output logic [1:0]            state
);

  localparam int HALF = 1 << (ADDR_WIDTH - 1);
  // Dump counter value at which the final bin is on the display port.
  localparam logic [ADDR_WIDTH-1:0]   LAST_CNT  = ADDR_WIDTH'(HALF);
  // Watchdog value in the last RUN cycle; the counter would reach all-ones next.
  localparam logic [TIMEOUT_BITS-1:0] WDOG_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DUMP = 2'd3
  } state_t;

  state_t                  r_state;
  logic                    r_ram_we;
  logic [ADDR_WIDTH-1:0]   r_ram_addr;
  logic [DATA_WIDTH-1:0]   r_ram_wdata;
  logic                    r_fft_start;
  logic [TIMEOUT_BITS-1:0] r_wdog;
  logic [ADDR_WIDTH-1:0]   r_dump_cnt;
  logic                    r_disp_we;
  logic [ADDR_WIDTH-2:0]   r_disp_addr;
  logic                    r_frame_ready;
  logic                    r_timeout;
  logic                    r_drop;
  logic [7:0]              r_overrun;

  logic                    w_addr_zero;
  logic                    w_frame_begin;
  logic                    w_accept;
  logic                    w_busy;
  logic                    w_wdog_expire;
  logic                    w_to_idle;
  logic                    w_overrun_hit;
  logic [OUT_WIDTH-1:0]    w_scaled;
  logic [OUT_WIDTH-1:0]    w_disp_val;

  // Scale a magnitude down by SHIFT and clamp it into the display width.
  function automatic logic [OUT_WIDTH-1:0] sat_scale(input logic [DATA_WIDTH-1:0] mag);
    logic [DATA_WIDTH-1:0] sh;
    sh = mag >> SHIFT;
    if (|(sh >> OUT_WIDTH)) begin
      sat_scale = {OUT_WIDTH{1'b1}};
    end else begin
      sat_scale = sh[OUT_WIDTH-1:0];
    end
  endfunction

  assign w_addr_zero   = (mic_addr == {ADDR_WIDTH{1'b0}});
  assign w_frame_begin = mic_we & w_addr_zero;
  assign w_accept      = mic_we & ((r_state == S_LOAD) | ((r_state == S_IDLE) & w_addr_zero));
  assign w_busy        = (r_state == S_RUN) | (r_state == S_DUMP);
  assign w_wdog_expire = (r_wdog == WDOG_LAST);
  assign w_to_idle     = ((r_state == S_RUN) & ~fft_done & w_wdog_expire) |
                         ((r_state == S_DUMP) & (r_dump_cnt == LAST_CNT));
  // The drop flag can never be set in LOAD, so no LOAD qualifier is needed here.
  assign w_overrun_hit = mic_start & r_drop & (r_state != S_LOAD);
  assign w_scaled      = sat_scale(fft_rd_data);

`ifdef FFT_PEAK_HOLD_EN
  logic [OUT_WIDTH-1:0] r_hold [HALF];
  logic [OUT_WIDTH-1:0] w_hold_dec;

  // Decayed hold value for the bin on the display port, then the larger of it and the new value.
  always_comb begin
    if (r_hold[r_disp_addr] != {OUT_WIDTH{1'b0}}) begin
      w_hold_dec = r_hold[r_disp_addr] - {{(OUT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      w_hold_dec = {OUT_WIDTH{1'b0}};
    end
    if (w_scaled > w_hold_dec) begin
      w_disp_val = w_scaled;
    end else begin
      w_disp_val = w_hold_dec;
    end
  end

  // Remember what was shown for each bin so the next frame can decay from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HALF; i++) begin
        r_hold[i] <= {OUT_WIDTH{1'b0}};
      end
    end else if (r_disp_we) begin
      r_hold[r_disp_addr] <= w_disp_val;
    end
  end
`else
  assign w_disp_val = w_scaled;
`endif

  // Registered write gate towards the shared sample RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ram_we    <= 1'b0;
      r_ram_addr  <= {ADDR_WIDTH{1'b0}};
      r_ram_wdata <= {DATA_WIDTH{1'b0}};
    end else begin
      r_ram_we    <= w_accept;
      r_ram_addr  <= mic_addr;
      r_ram_wdata <= mic_data;
    end
  end

  // Frame sequencer: state, FFT launch, watchdog and spectrum dump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_fft_start   <= 1'b0;
      r_wdog        <= {TIMEOUT_BITS{1'b0}};
      r_dump_cnt    <= {ADDR_WIDTH{1'b0}};
      r_disp_we     <= 1'b0;
      r_disp_addr   <= {(ADDR_WIDTH-1){1'b0}};
      r_frame_ready <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_fft_start   <= 1'b0;
      r_frame_ready <= 1'b0;
      r_disp_we     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_frame_begin) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (mic_start) begin
            r_state     <= S_RUN;
            r_fft_start <= 1'b1;
            r_wdog      <= {TIMEOUT_BITS{1'b0}};
          end
        end
        S_RUN: begin
          // A completion in the expiry cycle still gets dumped.
          if (fft_done) begin
            r_state    <= S_DUMP;
            r_dump_cnt <= {ADDR_WIDTH{1'b0}};
          end else if (w_wdog_expire) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_wdog <= r_wdog + {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};
          end
        end
        S_DUMP: begin
          // The read address issued this cycle is written to the display next cycle.
          if (r_dump_cnt == LAST_CNT) begin
            r_state       <= S_IDLE;
            r_frame_ready <= 1'b1;
            r_dump_cnt    <= {ADDR_WIDTH{1'b0}};
          end else begin
            r_disp_we   <= 1'b1;
            r_disp_addr <= r_dump_cnt[ADDR_WIDTH-2:0];
            r_dump_cnt  <= r_dump_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Drop flag and saturating overrun counter for frames offered while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop    <= 1'b0;
      r_overrun <= 8'd0;
    end else begin
      if (w_to_idle) begin
        r_drop <= 1'b0;
      end else if (w_frame_begin & w_busy) begin
        r_drop <= 1'b1;
      end else if (w_overrun_hit) begin
        r_drop <= 1'b0;
      end else begin
        r_drop <= r_drop;
      end
      if (w_overrun_hit && (r_overrun != 8'hFF)) begin
        r_overrun <= r_overrun + 8'd1;
      end else begin
        r_overrun <= r_overrun;
      end
    end
  end

  assign ram_we      = r_ram_we;
  assign ram_addr    = r_ram_addr;
  assign ram_wdata   = r_ram_wdata;
  assign fft_start   = r_fft_start;
  assign fft_rd_addr = r_dump_cnt[ADDR_WIDTH-2:0];
  assign disp_we     = r_disp_we;
  assign disp_addr   = r_disp_addr;
  // The magnitude arrives one cycle after its read address, in step with the
  // registered disp_we/disp_addr, so the scaled value is taken straight from
  // it and forced to zero whenever no bin is being written.
  assign disp_data   = r_disp_we ? w_disp_val : {OUT_WIDTH{1'b0}};
  assign frame_ready = r_frame_ready;
  assign overrun_cnt = r_overrun;
  assign fft_timeout = r_timeout;
  assign state       = r_state;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench for fft_frame_scheduler (default parameters, N = 64).
module tb_fft_frame_scheduler;

  localparam int AW   = 6;
  localparam int DW   = 18;
  localparam int OW   = 8;
  localparam int N    = 64;
  localparam int HALF = 32;
  localparam int RUN_LIMIT = 4095;  // RUN cycles before the watchdog gives up

  logic          clk = 1'b0;
  logic          rst;
  logic          mic_we, mic_start, fft_done;
  logic [AW-1:0] mic_addr;
  logic [DW-1:0] mic_data;
  logic          ram_we, fft_start, disp_we, frame_ready, fft_timeout;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, fft_rd_data;
  logic [AW-2:0] fft_rd_addr, disp_addr;
  logic [OW-1:0] disp_data;
  logic [7:0]    overrun_cnt;
  logic [1:0]    state;

  always #5 clk = ~clk;

  fft_frame_scheduler dut (
    .clk(clk), .rst(rst), .mic_we(mic_we), .mic_addr(mic_addr), .mic_data(mic_data),
    .mic_start(mic_start), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .fft_start(fft_start), .fft_done(fft_done), .fft_rd_addr(fft_rd_addr),
    .fft_rd_data(fft_rd_data), .disp_we(disp_we), .disp_addr(disp_addr),
    .disp_data(disp_data), .frame_ready(frame_ready), .overrun_cnt(overrun_cnt),
    .fft_timeout(fft_timeout), .state(state)
  );

  // FFT spectrum memory with one cycle of read latency.
  logic [DW-1:0] fmem [HALF];
  always @(posedge clk) fft_rd_data <= fmem[fft_rd_addr];

  int n_checks = 0;
  int n_pass   = 0;
  int dq_addr[$];
  int dq_data[$];
  int exp_q[$];
  int n_ready, n_start, n_ramwe, n_run;
  int hold_m[HALF];
  int exp_ovr = 0;

  typedef struct {
    logic [DW-1:0] mag;
    int            exp;
  } vec_t;
  vec_t vt[HALF];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: magnitude / 2^SHIFT clamped to 255, optionally with peak hold.
  function automatic int ref_bin(input int i, input int mag);
    int s;
    int h;
    s = mag / 1024;
    if (s > 255) s = 255;
    h = 0;
`ifdef FFT_PEAK_HOLD_EN
    h = (hold_m[i] > 0) ? hold_m[i] - 1 : 0;
    if (h > s) s = h;
    hold_m[i] = s;
`endif
    return s + 0 * h;
  endfunction

  task automatic clear_hold();
    for (int i = 0; i < HALF; i++) hold_m[i] = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    if (disp_we) begin
      dq_addr.push_back(int'(disp_addr));
      dq_data.push_back(int'(disp_data));
    end
    if (frame_ready) n_ready++;
    if (fft_start) n_start++;
    if (ram_we) n_ramwe++;
    if (state == 2'd2) n_run++;
  endtask

  task automatic clear_mon();
    dq_addr.delete();
    dq_data.delete();
    n_ready = 0; n_start = 0; n_ramwe = 0; n_run = 0;
  endtask

  // Write a full frame from IDLE and launch the FFT.
  task automatic load_frame();
    int errs;
    logic [DW-1:0] d;
    errs = 0;
    clear_mon();
    for (int a = 0; a < N; a++) begin
      d = DW'($urandom);
      mic_we = 1'b1; mic_addr = AW'(a); mic_data = d;
      cyc();
      if (!(ram_we === 1'b1 && ram_addr === AW'(a) && ram_wdata === d)) errs++;
    end
    mic_we = 1'b0;
    check("load_gate_errs", errs, 0);
    check("load_ram_we_cycles", n_ramwe, N);
    mic_start = 1'b1; cyc(); mic_start = 1'b0;
    check("fft_start_pulse", fft_start, 1);
    check("state_run", state, 2);
    cyc();
    check("fft_start_one_cycle", n_start, 1);
  endtask

  // Complete the FFT after 'delay' cycles and check the dump against the model.
  task automatic dump_frame(input int delay, input bit inject);
    int cnt, errs, ramwe0;
    bit got;
    exp_q.delete();
    for (int i = 0; i < HALF; i++) exp_q.push_back(ref_bin(i, int'(fmem[i])));
    repeat (delay) cyc();
    fft_done = 1'b1; cyc(); fft_done = 1'b0;
    check("state_dump", state, 3);
    dq_addr.delete(); dq_data.delete(); n_ready = 0;
    ramwe0 = n_ramwe;
    cnt = 0; got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (inject && i >= 2 && i < 22) begin
        mic_we = 1'b1; mic_addr = AW'(i - 2); mic_data = DW'($urandom);
      end else begin
        mic_we = 1'b0;
      end
      mic_start = (inject && i == 22);
      cyc();
      cnt++;
      if (frame_ready) got = 1'b1;
    end
    mic_we = 1'b0; mic_start = 1'b0;
    check("frame_ready_seen", got, 1);
    check("dump_latency", cnt, HALF + 1);
    check("state_idle_at_ready", state, 0);
    cyc();
    check("frame_ready_one_cycle", n_ready, 1);
    check("disp_count", dq_data.size(), HALF);
    errs = 0;
    for (int i = 0; i < HALF && i < dq_data.size(); i++)
      if (dq_addr[i] != i || dq_data[i] != exp_q[i]) errs++;
    check("dump_bins", errs, 0);
    if (inject) begin
      if (exp_ovr < 255) exp_ovr++;
      check("dump_frame_ram_we_blocked", n_ramwe - ramwe0, 0);
      check("overrun_after_dump_drop", overrun_cnt, exp_ovr);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int errs, act, bound;
    rst = 1'b1; mic_we = 1'b0; mic_addr = '0; mic_data = '0; mic_start = 1'b0; fft_done = 1'b0;
    clear_hold();
    for (int i = 0; i < HALF; i++) fmem[i] = '0;
    // Saturation/scaling table: {magnitude, expected display value}.
    vt[0]  = '{18'd0,      0};   vt[1]  = '{18'd1023,   0};
    vt[2]  = '{18'd1024,   1};   vt[3]  = '{18'h3FFFF,  255};
    vt[4]  = '{18'd261120, 255}; vt[5]  = '{18'h3FBFF,  254};
    vt[6]  = '{18'h20000,  128}; vt[7]  = '{18'h1FFFF,  127};
    vt[8]  = '{18'd204800, 200}; vt[9]  = '{18'd2047,   1};
    vt[10] = '{18'h3FC00,  255}; vt[11] = '{18'h3F000,  252};
    for (int i = 12; i < HALF; i++) vt[i] = '{DW'(i * 1024), i};

    repeat (3) @(negedge clk);
    check("reset_outputs", longint'({ram_we, ram_addr, ram_wdata, fft_start, fft_rd_addr, disp_we,
          disp_addr, disp_data, frame_ready, overrun_cnt, fft_timeout, state}), 0);
    rst = 1'b0;

    // IDLE ignores mic_start and writes away from address 0.
    clear_mon();
    mic_start = 1'b1; cyc(); mic_start = 1'b0;
    mic_we = 1'b1; mic_addr = 6'd5; cyc(); mic_addr = 6'd63; cyc(); mic_we = 1'b0; cyc();
    check("idle_ignore_ram_we", n_ramwe, 0);
    check("idle_state", state, 0);
    check("idle_no_fft_start", n_start, 0);

    // Table-driven scaling frame.
    for (int i = 0; i < HALF; i++) fmem[i] = vt[i].mag;
    load_frame();
    dump_frame(3, 1'b0);
    for (int i = 0; i < HALF; i++) begin
      act = (i < dq_data.size()) ? dq_data[i] : -1;
      check($sformatf("table_bin%0d", i), act, vt[i].exp);
    end

    // Restart with address 0 while loading stays in LOAD.
    clear_mon();
    mic_we = 1'b1; mic_addr = 6'd0; cyc();
    check("load_entered", state, 1);
    mic_addr = 6'd7; cyc(); mic_addr = 6'd0; cyc(); mic_we = 1'b0;
    check("load_restart_state", state, 1);
    check("load_restart_ram_we", ram_we, 1);

    // Ramp frame: bin*1024 displays as 0..31.
    for (int i = 0; i < HALF; i++) fmem[i] = DW'(i * 1024);
    load_frame();
    dump_frame(0, 1'b0);

    // fft_done arriving in the expiry cycle still dumps.
    load_frame();
    repeat (RUN_LIMIT - 2) cyc();
    check("run_before_expiry", n_run, RUN_LIMIT);
    check("still_run_at_expiry", state, 2);
    dump_frame(0, 1'b0);
    check("no_timeout_when_done_wins", fft_timeout, 0);

    // Watchdog expiry without fft_done.
    load_frame();
    bound = 0;
    while (state == 2'd2 && bound < 5000) begin cyc(); bound++; end
    check("timeout_run_cycles", n_run, RUN_LIMIT);
    check("timeout_flag", fft_timeout, 1);
    check("timeout_state", state, 0);
    check("timeout_no_disp", dq_data.size(), 0);
    for (int i = 0; i < HALF; i++) fmem[i] = DW'($urandom_range(0, 262143));
    load_frame();
    dump_frame(5, 1'b0);
    check("timeout_sticky", fft_timeout, 1);

    // New frame offered during DUMP is dropped and counted.
    load_frame();
    dump_frame(2, 1'b1);
    clear_mon();
    for (int a = 20; a < N; a++) begin mic_we = 1'b1; mic_addr = AW'(a); cyc(); end
    mic_we = 1'b0; mic_start = 1'b1; cyc(); mic_start = 1'b0; cyc();
    check("abandoned_tail_ignored", n_ramwe, 0);
    check("overrun_idle_start_ignored", overrun_cnt, exp_ovr);

    // Saturation of the overrun counter.
    load_frame();
    mic_start = 1'b1; cyc(); mic_start = 1'b0;
    check("overrun_needs_drop_flag", overrun_cnt, exp_ovr);
    n_ramwe = 0;
    for (int i = 0; i < 300; i++) begin
      mic_we = 1'b1; mic_addr = 6'd0; cyc(); mic_we = 1'b0;
      mic_start = 1'b1; cyc(); mic_start = 1'b0;
      if (exp_ovr < 255) exp_ovr++;
      if (i == 253) check("overrun_reaches_255", overrun_cnt, exp_ovr);
    end
    check("overrun_saturated", overrun_cnt, 255);
    check("busy_writes_blocked", n_ramwe, 0);
    dump_frame(0, 1'b0);

    // Randomized frames against the model.
    for (int f = 0; f < 5; f++) begin
      clear_mon();
      repeat ($urandom_range(1, 4)) begin
        mic_we = 1'b1; mic_addr = AW'($urandom_range(1, 63)); mic_data = DW'($urandom); cyc();
      end
      mic_we = 1'b0;
      check("rand_idle_ignored", n_ramwe, 0);
      for (int i = 0; i < HALF; i++)
        fmem[i] = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 262143)) : DW'($urandom_range(0, 40000));
      load_frame();
      dump_frame($urandom_range(0, 15), 1'b0);
    end

    // Reset in the middle of a dump.
    for (int i = 0; i < HALF; i++) fmem[i] = DW'(i * 1024 + 512);
    load_frame();
    fft_done = 1'b1; cyc(); fft_done = 1'b0;
    bound = 0;
    while (!(disp_we && disp_addr == 5'd10) && bound < 40) begin cyc(); bound++; end
    check("reached_bin10", disp_addr, 10);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", longint'({ram_we, ram_addr, ram_wdata, fft_start, fft_rd_addr, disp_we,
          disp_addr, disp_data, frame_ready, overrun_cnt, fft_timeout, state}), 0);
    clear_hold();
    exp_ovr = 0;
    n_ready = 0;
    repeat (2) cyc();
    rst = 1'b0;
    repeat (4) cyc();
    check("no_ready_after_abort", n_ready, 0);
    check("idle_after_abort", state, 0);
    load_frame();
    dump_frame(1, 1'b0);

`ifdef FFT_PEAK_HOLD_EN
    for (int i = 0; i < HALF; i++) fmem[i] = DW'(200 * 1024);
    load_frame();
    dump_frame(0, 1'b0);
    for (int i = 0; i < HALF; i++) fmem[i] = '0;
    load_frame();
    dump_frame(0, 1'b0);
    act = (dq_data.size() > 0) ? dq_data[0] : -1;
    check("peak_hold_decay", act, 199);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
- Sequences one audio frame at a time from the mic capture path through the FFT engine into the display spectrum buffer.
- Gates mic writes into the shared sample RAM and launches the FFT.
- Supervises FFT completion with a timeout, then copies and scales the lower half-spectrum into the display buffer.
- Counts frames dropped because the pipeline was busy.

Parameters:
- ADDR_WIDTH, 6: log2 of FFT points N; display bins = N/2.
- DATA_WIDTH, 18: sample and FFT magnitude width.
- OUT_WIDTH, 8: display bin width.
- SHIFT, 10: right shift applied to each magnitude before saturation.
- TIMEOUT_BITS, 12: width of the FFT watchdog counter.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- mic_we  in  1  mic sample write strobe.
- mic_addr  in  ADDR_WIDTH  mic sample address.
- mic_data  in  DATA_WIDTH  mic sample.
- mic_start  in  1  one-cycle pulse: mic frame fully written.
- ram_we  out  1  gated write enable to the shared sample RAM.
- ram_addr  out  ADDR_WIDTH  registered copy of mic_addr.
- ram_wdata  out  DATA_WIDTH  registered copy of mic_data.
- fft_start  out  1  one-cycle FFT launch pulse.
- fft_done  in  1  one-cycle FFT completion pulse.
- fft_rd_addr  out  ADDR_WIDTH-1  spectrum read address.
- fft_rd_data  in  DATA_WIDTH  magnitude; 1-cycle read latency.
- disp_we  out  1  display buffer write enable.
- disp_addr  out  ADDR_WIDTH-1  display bin index.
- disp_data  out  OUT_WIDTH  scaled bin value.
- frame_ready  out  1  one-cycle pulse after the last bin is written.
- overrun_cnt  out  8  saturating count of dropped frames.
- fft_timeout  out  1  sticky; set on watchdog expiry.
- state  out  2  IDLE=0, LOAD=1, RUN=2, DUMP=3.

Behaviour:
- Reset values: all outputs 0; state=IDLE; internal drop flag and counters cleared. A reset mid-operation aborts the frame immediately with no frame_ready.
- Write gate:
  - ram_addr and ram_wdata register mic_addr and mic_data every cycle.
  - ram_we is registered (1-cycle latency) and equals mic_we only when the write is accepted: state is LOAD, or state is IDLE with mic_addr==0.
  - A write with mic_addr!=0 while IDLE is ignored.
- IDLE:
  - mic_we with mic_addr==0 -> LOAD; the write is accepted.
  - mic_start while IDLE -> ignored.
- LOAD:
  - mic_start -> RUN; fft_start=1 for exactly the next cycle.
  - mic_we with mic_addr==0 again (restart) stays in LOAD.
- RUN:
  - Watchdog clears on entry and increments each cycle.
  - fft_done -> DUMP.
  - Watchdog reaches 2^TIMEOUT_BITS-1 with no fft_done -> set fft_timeout, go IDLE, no dump.
  - fft_done in the same cycle as expiry -> fft_done wins.
- DUMP:
  - fft_rd_addr steps 0..N/2-1, one per cycle.
  - One cycle later: disp_we=1, disp_addr=previous fft_rd_addr, disp_data=sat(fft_rd_data>>SHIFT).
  - sat: if any bit above OUT_WIDTH-1 is set, output 2^OUT_WIDTH-1.
  - Last write at cycle N/2 after entry; frame_ready pulses in the following cycle, together with the return to IDLE.
- Overrun:
  - mic_we with mic_addr==0 in RUN or DUMP sets the drop flag.
  - mic_start while the drop flag is set and state is not LOAD -> overrun_cnt+1 (saturate at 255), flag cleared.
  - The drop flag also clears when the scheduler returns to IDLE; an abandoned frame is then never partially accepted.
- Simultaneous events:
  - mic_start and fft_done in the same cycle: each is handled by its own rule.
  - Watchdog expiry and the overrun count are independent.
- fft_timeout clears only on rst.

Optional Feature:
- Macro: FFT_PEAK_HOLD_EN.
- When defined:
  - An internal N/2 x OUT_WIDTH hold array is kept.
  - Each DUMP output is max(new, hold-1); hold-1 floors at 0.
  - The hold entry is updated with the output value.
  - The array clears on rst.
- When undefined: disp_data is the plain saturated value; no array exists.

Test Plan:
- Defaults (N=64). Write addr 0..63, pulse mic_start -> ram_we high for 64 cycles, each 1 cycle after mic_we; then fft_start exactly one cycle; state=2.
- fft_done, fft_rd_data=bin*1024 -> disp_we for 32 cycles, disp_addr 0..31, disp_data 0..31; then frame_ready one cycle; state=0.
- fft_rd_data=18'h3FFFF -> disp_data=8'hFF. fft_rd_data=1023 -> disp_data=0.
- Withhold fft_done -> fft_timeout=1 after 4095 RUN cycles; state=0; no disp_we. A later frame still completes.
- New frame written during DUMP, then mic_start -> ram_we stays 0 for it, overrun_cnt=1. 256 overruns -> overrun_cnt holds at 255.
- Assert rst mid-DUMP (bin 10) -> outputs 0 asynchronously; no frame_ready. A new frame after release dumps all 32 bins. With FFT_PEAK_HOLD_EN, a frame of 200s then a frame of 0s gives 199 on the second dump.
